// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Arbitrates PC redirects, runs the icache line refill handshake and generates the fetch stall.
// Latency: a redirect requested in IDLE (or DONE) is strobed on the next cycle. A miss enters REQ on the next cycle. Refill beats are written into the icache in the same cycle they arrive.
// Backpressure: mem_req_o is held until mem_gnt_i. Redirects that arrive during a refill are parked and replayed in DONE. A stalled memory port raises a sticky bus error after TIMEOUT idle cycles.
//
// Ports:
//   clk_i, rsn_i                 clock, async active-low reset
//   pc_i, icache_hit_i           current fetch PC and its icache lookup result
//   exc_occured_i / iret_i /     redirect requests, in priority order exc > iret > mispredict > jal
//   br_mispred_i / jal_i (+pc)
//   mem_req_o/mem_addr_o/mem_gnt_i           line fill request channel
//   mem_rvalid_i/mem_rdata_i                 refill beats
//   fill_we_o/fill_idx_o/fill_data_o         icache word write
//   redirect_o/redirect_pc_o                 one-cycle PC load strobe
//   stall_fetch_o, bus_err_o                 fetch hold, sticky refill timeout
// Optional: define FETCH_PERF_CNT_EN to add the miss_cnt_o and stall_cnt_o performance counters.

module fetch_ctrl #(
    parameter int          LINE_WORDS = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] EXC_VECTOR = 32'h2000
) (
    input  logic                          clk_i,
    input  logic                          rsn_i,
    input  logic [31:0]                   pc_i,
    input  logic                          icache_hit_i,
    input  logic                          exc_occured_i,
    input  logic                          iret_i,
    input  logic [31:0]                   exc_return_pc_i,
    input  logic                          br_mispred_i,
    input  logic [31:0]                   br_pc_i,
    input  logic                          jal_i,
    input  logic [31:0]                   jal_pc_i,
    output logic                          mem_req_o,
    output logic [31:0]                   mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic                          fill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx_o,
    output logic [31:0]                   fill_data_o,
    output logic                          redirect_o,
    output logic [31:0]                   redirect_pc_o,
    output logic                          stall_fetch_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                   miss_cnt_o,
    output logic [31:0]                   stall_cnt_o,
`endif
    output logic                          bus_err_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  beat_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              pend_vld;
    logic [1:0]        pend_lvl;
    logic [31:0]       pend_pc;

    // Line-offset bits of the PC do not take part in the fill address.
    logic              unused_pc_bits;
    assign unused_pc_bits = ^pc_i[OFF_W-1:0];

    // Redirect arbitration. The level encodes priority so that a parked
    // request can be compared against a newer one.
    logic              req_vld;
    logic [1:0]        req_lvl;
    logic [31:0]       req_pc;

    always_comb begin
        req_vld = exc_occured_i | iret_i | br_mispred_i | jal_i;
        req_lvl = 2'd0;
        req_pc  = jal_pc_i;
        if (exc_occured_i) begin
            req_lvl = 2'd3;
            req_pc  = EXC_VECTOR;
        end else if (iret_i) begin
            req_lvl = 2'd2;
            req_pc  = exc_return_pc_i;
        end else if (br_mispred_i) begin
            req_lvl = 2'd1;
            req_pc  = br_pc_i;
        end
    end

    // Pending slot merged with this cycle's request. An equal-priority
    // request replaces the parked one, so the youngest target of that kind wins.
    logic              take_req;
    logic              merged_vld;
    logic [1:0]        merged_lvl;
    logic [31:0]       merged_pc;

    always_comb begin
        take_req   = req_vld && (!pend_vld || (req_lvl >= pend_lvl));
        merged_vld = pend_vld | req_vld;
        merged_lvl = take_req ? req_lvl : pend_lvl;
        merged_pc  = take_req ? req_pc  : pend_pc;
    end

    // Progress means a grant in REQ or a beat in FILL. Any other REQ/FILL
    // cycle counts toward the timeout.
    logic              busy_mem;
    logic              progress;
    logic              timeout_hit;
    logic              last_beat;

    always_comb begin
        busy_mem    = (state == REQ) || (state == FILL);
        progress    = ((state == REQ) && mem_gnt_i) || ((state == FILL) && mem_rvalid_i);
        timeout_hit = busy_mem && !progress && (wait_cnt == TO_W'(TIMEOUT - 1));
        last_beat   = (state == FILL) && mem_rvalid_i && (beat_cnt == IDX_W'(LINE_WORDS - 1));
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            pend_vld      <= 1'b0;
            pend_lvl      <= 2'd0;
            pend_pc       <= '0;
            mem_addr_o    <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            bus_err_o     <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_vld) begin
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= req_pc;
                    end else if (!icache_hit_i) begin
                        state      <= REQ;
                        mem_addr_o <= {pc_i[31:OFF_W], {OFF_W{1'b0}}};
                        wait_cnt   <= '0;
                    end
                end
                REQ, FILL: begin
                    if (timeout_hit) begin
                        // Abandon the refill. The parked redirect is stale, so fetch goes to the exception vector instead.
                        state         <= IDLE;
                        bus_err_o     <= 1'b1;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= EXC_VECTOR;
                        pend_vld      <= 1'b0;
                    end else begin
                        pend_vld <= merged_vld;
                        pend_lvl <= merged_lvl;
                        pend_pc  <= merged_pc;
                        wait_cnt <= progress ? '0 : wait_cnt + TO_W'(1);
                        if ((state == REQ) && mem_gnt_i) begin
                            state    <= FILL;
                            beat_cnt <= '0;
                        end
                        if ((state == FILL) && mem_rvalid_i) begin
                            beat_cnt <= beat_cnt + IDX_W'(1);
                            if (last_beat) begin
                                // The line is complete, so the parked redirect is strobed during DONE.
                                state      <= DONE;
                                redirect_o <= merged_vld;
                                if (merged_vld) begin
                                    redirect_pc_o <= merged_pc;
                                end
                                pend_vld <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (req_vld) begin
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= req_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat writes pass straight through so the icache sees each word in the cycle it arrives.
    always_comb begin
        mem_req_o     = (state == REQ);
        fill_we_o     = (state == FILL) && mem_rvalid_i;
        fill_idx_o    = fill_we_o ? beat_cnt : '0;
        fill_data_o   = fill_we_o ? mem_rdata_i : '0;
        // Gated by reset so the stall drops immediately when reset is asserted.
        stall_fetch_o = rsn_i && ((state != IDLE) || (!icache_hit_i && !req_vld));
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            miss_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if ((state == IDLE) && !req_vld && !icache_hit_i) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
            if (stall_fetch_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
